// File: rtl/lcd_fill_rect.sv
// Rectangle fill sequencer for an ST77xx-style LCD: emits CASET/RASET/RAMWR and
// then one RGB565 pixel (two data bytes) per pixel, handshaking word by word with an SPI writer.
module lcd_fill_rect #(
    parameter logic [7:0] X_OFS = 8'd0,
    parameter logic [7:0] Y_OFS = 8'd0
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    input  logic [7:0]  x_start,
    input  logic [7:0]  x_end,
    input  logic [7:0]  y_start,
    input  logic [7:0]  y_end,
    input  logic [15:0] color,
    input  logic        wr_done,
    output logic [8:0]  fill_data,
    output logic        en_write_fill,
    output logic        busy,
    output logic        fill_done,
    output logic        fill_err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        PIX_HI = 3'd2,
        PIX_LO = 3'd3,
        WAIT   = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [8:0] CMD_CASET = 9'h02A;
    localparam logic [8:0] CMD_RASET = 9'h02B;
    localparam logic [8:0] CMD_RAMWR = 9'h02C;
    localparam logic [8:0] DATA_ZERO = 9'h100;
    localparam logic [3:0] LAST_STEP = 4'd10;

    state_t      state_reg, state_next;
    state_t      sent_reg, sent_next;
    logic [3:0]  step_reg, step_next;
    logic [16:0] pix_cnt_reg, pix_cnt_next;
    logic [7:0]  xs_reg, xs_next;
    logic [7:0]  xe_reg, xe_next;
    logic [7:0]  ys_reg, ys_next;
    logic [7:0]  ye_reg, ye_next;
    logic [15:0] color_reg, color_next;
    logic [8:0]  data_reg, data_next;
    logic        err_reg, err_next;

    logic        rect_ok;
    logic [8:0]  width;
    logic [8:0]  height;
    logic [16:0] area;
    logic [3:0]  step_inc;
    logic [8:0]  next_setup_word;

    // 9-bit spans so a full 256-wide/high rectangle does not wrap to zero
    assign rect_ok  = (x_end >= x_start) && (y_end >= y_start);
    assign width    = {1'b0, x_end} - {1'b0, x_start} + 9'd1;
    assign height   = {1'b0, y_end} - {1'b0, y_start} + 9'd1;
    assign area     = 17'(width) * 17'(height);
    assign step_inc = step_reg + 4'd1;

    always_comb begin
        next_setup_word = CMD_RAMWR;
        case (step_inc)
            4'd1, 4'd3, 4'd6, 4'd8: next_setup_word = DATA_ZERO;
            4'd2:    next_setup_word = {1'b1, xs_reg + X_OFS};
            4'd4:    next_setup_word = {1'b1, xe_reg + X_OFS};
            4'd5:    next_setup_word = CMD_RASET;
            4'd7:    next_setup_word = {1'b1, ys_reg + Y_OFS};
            4'd9:    next_setup_word = {1'b1, ye_reg + Y_OFS};
            default: next_setup_word = CMD_RAMWR;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg   <= IDLE;
            sent_reg    <= IDLE;
            step_reg    <= 4'd0;
            pix_cnt_reg <= 17'd0;
            xs_reg      <= 8'd0;
            xe_reg      <= 8'd0;
            ys_reg      <= 8'd0;
            ye_reg      <= 8'd0;
            color_reg   <= 16'd0;
            data_reg    <= 9'd0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            sent_reg    <= sent_next;
            step_reg    <= step_next;
            pix_cnt_reg <= pix_cnt_next;
            xs_reg      <= xs_next;
            xe_reg      <= xe_next;
            ys_reg      <= ys_next;
            ye_reg      <= ye_next;
            color_reg   <= color_next;
            data_reg    <= data_next;
            err_reg     <= err_next;
        end
    end

    // The word to send is registered on the same edge that enters a sending state,
    // so each request follows the accepting edge (start or wr_done) by exactly one cycle.
    always_comb begin
        state_next    = state_reg;
        sent_next     = sent_reg;
        step_next     = step_reg;
        pix_cnt_next  = pix_cnt_reg;
        xs_next       = xs_reg;
        xe_next       = xe_reg;
        ys_next       = ys_reg;
        ye_next       = ye_reg;
        color_next    = color_reg;
        data_next     = data_reg;
        err_next      = 1'b0;
        en_write_fill = 1'b0;
        busy          = 1'b0;
        fill_done     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (rect_ok) begin
                        xs_next      = x_start;
                        xe_next      = x_end;
                        ys_next      = y_start;
                        ye_next      = y_end;
                        color_next   = color;
                        pix_cnt_next = area;
                        step_next    = 4'd0;
                        data_next    = CMD_CASET;
                        state_next   = SETUP;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end

            SETUP, PIX_HI, PIX_LO: begin
                en_write_fill = 1'b1;
                busy          = 1'b1;
                sent_next     = state_reg;
                state_next    = WAIT;
            end

            WAIT: begin
                busy = 1'b1;
                if (wr_done) begin
                    case (sent_reg)
                        SETUP: begin
                            if (step_reg == LAST_STEP) begin
                                data_next  = {1'b1, color_reg[15:8]};
                                state_next = PIX_HI;
                            end else begin
                                step_next  = step_inc;
                                data_next  = next_setup_word;
                                state_next = SETUP;
                            end
                        end
                        PIX_HI: begin
                            data_next  = {1'b1, color_reg[7:0]};
                            state_next = PIX_LO;
                        end
                        default: begin
                            pix_cnt_next = pix_cnt_reg - 17'd1;
                            if (pix_cnt_reg == 17'd1) begin
                                state_next = DONE;
                            end else begin
                                data_next  = {1'b1, color_reg[15:8]};
                                state_next = PIX_HI;
                            end
                        end
                    endcase
                end
            end

            DONE: begin
                fill_done  = 1'b1;
                state_next = IDLE;
            end

            default: state_next = IDLE;
        endcase
    end

    assign fill_data = data_reg;
    assign fill_err  = err_reg;

endmodule

// File: tb/tb_lcd_fill_rect.sv
// Scoreboard bench for lcd_fill_rect: two instances (no offset, X_OFS=2/Y_OFS=1)
// driven in parallel, a latency-programmable writer model, and one checking monitor.
module tb_lcd_fill_rect;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        start;
    logic [7:0]  x_start, x_end, y_start, y_end;
    logic [15:0] color;
    logic        wr_done_a, wr_done_b;
    logic [8:0]  fill_data_a, fill_data_b;
    logic        en_a, en_b, busy_a, busy_b, done_a, done_b, err_a, err_b;

    lcd_fill_rect #(.X_OFS(8'd0), .Y_OFS(8'd0)) dut_a (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start),
        .x_start(x_start), .x_end(x_end), .y_start(y_start), .y_end(y_end),
        .color(color), .wr_done(wr_done_a), .fill_data(fill_data_a),
        .en_write_fill(en_a), .busy(busy_a), .fill_done(done_a), .fill_err(err_a)
    );

    lcd_fill_rect #(.X_OFS(8'd2), .Y_OFS(8'd1)) dut_b (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start),
        .x_start(x_start), .x_end(x_end), .y_start(y_start), .y_end(y_end),
        .color(color), .wr_done(wr_done_b), .fill_data(fill_data_b),
        .en_write_fill(en_b), .busy(busy_b), .fill_done(done_b), .fill_err(err_b)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // stimulus-owned
    logic [8:0] exp_q_a[$];
    logic [8:0] exp_q_b[$];
    int exp_starts [2] = '{0, 0};
    int start_cyc = -10;
    int first_cyc = -10;
    int err_cyc   = -10;
    int wr_lat    = 3;
    bit stray     = 1'b0;
    // writer-owned
    int real_done [2] = '{-10, -10};
    int pend [2] = '{0, 0};
    bit prev_real [2] = '{1'b0, 1'b0};
    // monitor-owned
    int dones_seen [2] = '{0, 0};
    int en_cnt [2] = '{0, 0};
    int last_en [2] = '{-10, -10};
    int n_checks = 0;
    int n_fail   = 0;

    // Writer model: wr_done wr_lat cycles after each request; in stray mode also
    // pulses in the request cycle and in the cycle after every genuine wr_done.
    initial begin
        bit w [2];
        bit en_s [2];
        wr_done_a = 1'b0;
        wr_done_b = 1'b0;
        forever begin
            @(negedge sys_clk);
            en_s[0] = en_a;
            en_s[1] = en_b;
            for (int i = 0; i < 2; i++) begin
                w[i] = 1'b0;
                if (!sys_rst_n) begin
                    pend[i] = 0;
                    prev_real[i] = 1'b0;
                end else begin
                    if (stray && prev_real[i]) w[i] = 1'b1;
                    prev_real[i] = 1'b0;
                    if (pend[i] > 0) begin
                        pend[i]--;
                        if (pend[i] == 0) begin
                            w[i] = 1'b1;
                            real_done[i] = cyc;
                            prev_real[i] = 1'b1;
                        end
                    end
                    if (en_s[i]) begin
                        pend[i] = wr_lat;
                        if (stray) w[i] = 1'b1;
                    end
                end
            end
            wr_done_a = w[0];
            wr_done_b = w[1];
        end
    end

    task automatic mon_inst(input int i, input logic [8:0] dat, input logic en,
                            input logic bsy, input logic dn, input logic er,
                            input int qsize, input logic [8:0] qfront);
        string nm;
        bit pending, done_exp, busy_exp;
        nm       = (i == 0) ? "a" : "b";
        pending  = (exp_starts[i] != dones_seen[i]);
        done_exp = pending && (qsize == 0) && (real_done[i] == cyc - 1) && (real_done[i] > last_en[i]);
        busy_exp = pending && (cyc > start_cyc) && !done_exp;
        if (!sys_rst_n) begin
            n_checks++;
            if ({dat, en, bsy, dn, er} != 13'd0) begin
                n_fail++;
                $display("FAIL reset_outputs[%s] cyc %0d: data=%h en=%b busy=%b done=%b err=%b, required all 0",
                         nm, cyc, dat, en, bsy, dn, er);
            end
            return;
        end
        if (en) begin
            n_checks++;
            if (qsize == 0) begin
                n_fail++;
                $display("FAIL unexpected_write[%s] cyc %0d: got word %h, required no request", nm, cyc, dat);
            end else if (dat !== qfront) begin
                n_fail++;
                $display("FAIL word[%s] cyc %0d: got %h, required %h", nm, cyc, dat, qfront);
            end
            last_en[i] = cyc;
            en_cnt[i]++;
        end
        if (cyc == first_cyc) begin
            n_checks++;
            if (!en) begin
                n_fail++;
                $display("FAIL first_latency[%s] cyc %0d: en_write_fill=%b, required 1", nm, cyc, en);
            end
        end
        if (dn || done_exp) begin
            n_checks++;
            if (dn != done_exp) begin
                n_fail++;
                $display("FAIL fill_done[%s] cyc %0d: got %b, required %b", nm, cyc, dn, done_exp);
            end
            if (dn) dones_seen[i]++;
        end
        if (er || (cyc == err_cyc)) begin
            n_checks++;
            if (er != (cyc == err_cyc)) begin
                n_fail++;
                $display("FAIL fill_err[%s] cyc %0d: got %b, required %b", nm, cyc, er, (cyc == err_cyc));
            end
        end
        n_checks++;
        if (bsy != busy_exp) begin
            n_fail++;
            $display("FAIL busy[%s] cyc %0d: got %b, required %b", nm, cyc, bsy, busy_exp);
        end
    endtask

    always @(negedge sys_clk) begin
        logic [8:0] fa, fb;
        int sa, sb;
        sa = exp_q_a.size();
        sb = exp_q_b.size();
        fa = (sa > 0) ? exp_q_a[0] : 9'h000;
        fb = (sb > 0) ? exp_q_b[0] : 9'h000;
        mon_inst(0, fill_data_a, en_a, busy_a, done_a, err_a, sa, fa);
        mon_inst(1, fill_data_b, en_b, busy_b, done_b, err_b, sb, fb);
        if (sys_rst_n && en_a && sa > 0) void'(exp_q_a.pop_front());
        if (sys_rst_n && en_b && sb > 0) void'(exp_q_b.pop_front());
    end

    function automatic logic [8:0] setup_exp(input int k, input int xs, input int xe,
                                             input int ys, input int ye, input int xo, input int yo);
        case (k)
            0:       return 9'h02A;
            2:       return 9'h100 | 9'((xs + xo) % 256);
            4:       return 9'h100 | 9'((xe + xo) % 256);
            5:       return 9'h02B;
            7:       return 9'h100 | 9'((ys + yo) % 256);
            9:       return 9'h100 | 9'((ye + yo) % 256);
            10:      return 9'h02C;
            default: return 9'h100;
        endcase
    endfunction

    task automatic push_fill(input int xs, input int xe, input int ys, input int ye, input logic [15:0] col);
        int n;
        for (int k = 0; k < 11; k++) begin
            exp_q_a.push_back(setup_exp(k, xs, xe, ys, ye, 0, 0));
            exp_q_b.push_back(setup_exp(k, xs, xe, ys, ye, 2, 1));
        end
        n = (xe - xs + 1) * (ye - ys + 1);
        for (int p = 0; p < n; p++) begin
            exp_q_a.push_back({1'b1, col[15:8]});
            exp_q_a.push_back({1'b1, col[7:0]});
            exp_q_b.push_back({1'b1, col[15:8]});
            exp_q_b.push_back({1'b1, col[7:0]});
        end
    endtask

    task automatic fill(input logic [7:0] xs, input logic [7:0] xe, input logic [7:0] ys,
                        input logic [7:0] ye, input logic [15:0] col, input bit ok);
        @(negedge sys_clk);
        x_start = xs;
        x_end   = xe;
        y_start = ys;
        y_end   = ye;
        color   = col;
        start   = 1'b1;
        if (ok) begin
            push_fill(int'(xs), int'(xe), int'(ys), int'(ye), col);
            start_cyc = cyc;
            first_cyc = cyc + 1;
            exp_starts[0]++;
            exp_starts[1]++;
        end else begin
            err_cyc = cyc + 1;
        end
        @(negedge sys_clk);
        start   = 1'b0;
        x_start = 8'($urandom);
        x_end   = 8'($urandom);
        y_start = 8'($urandom);
        y_end   = 8'($urandom);
        color   = 16'($urandom);
    endtask

    task automatic wait_idle(input int max_cyc);
        int k = 0;
        while (exp_starts[0] != dones_seen[0] || exp_starts[1] != dones_seen[1]) begin
            @(negedge sys_clk);
            k++;
            if (k > max_cyc) begin
                $display("FAIL timeout waiting for fill_done after %0d cycles (a=%0d/%0d b=%0d/%0d)",
                         max_cyc, dones_seen[0], exp_starts[0], dones_seen[1], exp_starts[1]);
                $fatal(1, "fill did not complete");
            end
        end
    endtask

    initial begin
        int base;
        int k;
        start     = 1'b0;
        x_start   = 8'd0;
        x_end     = 8'd0;
        y_start   = 8'd0;
        y_end     = 8'd0;
        color     = 16'd0;
        sys_rst_n = 1'b1;
        #1 sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;

        // single pixel, then an immediate restart in the cycle after DONE
        fill(8'd5, 8'd5, 8'd5, 8'd5, 16'hF800, 1'b1);
        wait_idle(200);
        fill(8'd254, 8'd255, 8'd0, 8'd0, 16'h1234, 1'b1);
        wait_idle(300);

        // rejected rectangles
        fill(8'd10, 8'd9, 8'd0, 8'd0, 16'hFFFF, 1'b0);
        repeat (3) @(negedge sys_clk);
        fill(8'd0, 8'd0, 8'd4, 8'd3, 16'hFFFF, 1'b0);
        repeat (3) @(negedge sys_clk);

        // stray wr_done pulses plus a start while busy
        stray = 1'b1;
        fill(8'd1, 8'd3, 8'd2, 8'd3, 16'hABCD, 1'b1);
        repeat (20) @(negedge sys_clk);
        x_start = 8'd0;
        x_end   = 8'd50;
        y_start = 8'd0;
        y_end   = 8'd50;
        color   = 16'h0000;
        start   = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        wait_idle(500);
        stray = 1'b0;

        // 256-wide row and a large block with a fast writer
        wr_lat = 1;
        fill(8'd0, 8'd255, 8'd7, 8'd7, 16'h07E0, 1'b1);
        wait_idle(2000);
        fill(8'd0, 8'd127, 8'd0, 8'd39, 16'h07E0, 1'b1);
        wait_idle(25000);

        // reset after the 7th word, then a fresh fill
        wr_lat = 3;
        base = en_cnt[0];
        fill(8'd20, 8'd30, 8'd40, 8'd50, 16'h5555, 1'b1);
        k = 0;
        while (en_cnt[0] < base + 7) begin
            @(negedge sys_clk);
            k++;
            if (k > 200) begin
                $display("FAIL timeout waiting for 7th word, got %0d words", en_cnt[0] - base);
                $fatal(1, "word count not reached");
            end
        end
        @(posedge sys_clk);
        #1 sys_rst_n = 1'b0;
        exp_q_a.delete();
        exp_q_b.delete();
        exp_starts[0] = dones_seen[0];
        exp_starts[1] = dones_seen[1];
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        fill(8'd0, 8'd1, 8'd0, 8'd0, 16'h0F0F, 1'b1);
        wait_idle(300);
        repeat (3) @(negedge sys_clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
